// File: rtl/uart_rx_pkg.sv
// Shared constants, receiver state encoding and baud helper for the UART RX slice.
package uart_rx_pkg;

   localparam int unsigned UART_DATA_WIDTH    = 8;
   localparam int unsigned UART_RX_FIFO_DEPTH = 8;
   localparam int unsigned UART_FRAME_BITS    = 8;
   localparam int unsigned UART_BAUD_W        = 16;
   localparam int unsigned UART_BIT_CNT_W     = 3;

   localparam logic [UART_BAUD_W-1:0] UART_BAUD_DIV_MIN = UART_BAUD_W'(4);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_rx_state_e;

   // Clamp the programmed divider so the half-bit wait is never zero.
   function automatic logic [UART_BAUD_W-1:0] uart_eff_div(input logic [UART_BAUD_W-1:0] div);
      return (div < UART_BAUD_DIV_MIN) ? UART_BAUD_DIV_MIN : div;
   endfunction

endpackage

// File: rtl/wbit_fifo.sv
// Synchronous single-clock FIFO used as the UART RX buffer.
// Ports:
//   clk_i, rst_ni   clock, async active-low reset (empties the FIFO)
//   we_i, wdata_i   push request/data; ignored while full
//   re_i            pop request; ignored while empty
//   rdata_o         head entry; while empty it holds the last popped value
//   full_o, empty_o occupancy flags
module wbit_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             we_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             re_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, rd_ptr_q;
   logic [WIDTH-1:0] last_q;
   logic             wr_fire_c, rd_fire_c;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign empty_o   = (wr_ptr_q == rd_ptr_q);
   assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign wr_fire_c = we_i && !full_o;
   assign rd_fire_c = re_i && !empty_o;
   assign rdata_o   = empty_o ? last_q : mem_q[rd_ptr_q[AW-1:0]];

   // Storage array; contents are only observable through valid pointers.
   always_ff @(posedge clk_i) begin
      if (wr_fire_c) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
      end
   end

   // Pointers and the hold register for the empty-FIFO read value.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         last_q   <= '0;
      end else begin
         if (wr_fire_c) begin
            wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         end
         if (rd_fire_c) begin
            rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            last_q   <= mem_q[rd_ptr_q[AW-1:0]];
         end
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM and RX FIFO.
// Ports:
//   clk_i, rst_ni   clock, async active-low reset
//   baud_div_i      clocks per bit, clamped to a minimum of 4
//   rx_en_i         receiver enable; low aborts the current frame
//   rx_bit_i        asynchronous serial line, idle high
//   rx_re_i         pop the FIFO head
//   dout_o          FIFO head data
//   full_o, empty_o FIFO flags
//   frame_err_o     one-cycle pulse when the stop bit samples low
//   overrun_o       one-cycle pulse when a good byte is dropped on a full FIFO
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH,
   parameter int unsigned FIFO_DEPTH = UART_RX_FIFO_DEPTH
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [UART_BAUD_W-1:0] baud_div_i,
   input  logic                   rx_en_i,
   input  logic                   rx_bit_i,
   input  logic                   rx_re_i,
   output logic [DATA_WIDTH-1:0]  dout_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic                   frame_err_o,
   output logic                   overrun_o
);

   logic                       rx_meta_q, rx_s_q, rx_prev_q;
   uart_rx_state_e             state_q, state_d;
   logic [UART_BAUD_W-1:0]     baud_cnt_q, baud_cnt_d;
   logic [UART_BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [UART_FRAME_BITS-1:0] shift_q, shift_d;
   logic                       frame_err_q, frame_err_d;
   logic                       overrun_q, overrun_d;
   logic                       push_c;
   logic [UART_BAUD_W-1:0]     div_c, half_c;
   logic                       fifo_full, fifo_empty;

   assign div_c  = uart_eff_div(baud_div_i);
   assign half_c = div_c >> 1;

   // Synchronizer plus one delayed copy for falling-edge detection.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_meta_q <= rx_bit_i;
         rx_s_q    <= rx_meta_q;
         rx_prev_q <= rx_s_q;
      end
   end

   // FSM state and datapath registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         baud_cnt_q  <= '0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         baud_cnt_q  <= baud_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   // Next-state, sampling and push/error decisions.
   always_comb begin
      state_d     = state_q;
      baud_cnt_d  = baud_cnt_q + UART_BAUD_W'(1);
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
      push_c      = 1'b0;

      if (!rx_en_i) begin
         state_d    = IDLE;
         baud_cnt_d = '0;
         bit_cnt_d  = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               baud_cnt_d = '0;
               if (rx_prev_q && !rx_s_q) begin
                  state_d = START;
               end
            end
            START: begin
               // Half a bit in: a still-low line confirms a real start bit.
               if (baud_cnt_q == half_c - UART_BAUD_W'(1)) begin
                  baud_cnt_d = '0;
                  bit_cnt_d  = '0;
                  state_d    = rx_s_q ? IDLE : DATA;
               end
            end
            DATA: begin
               if (baud_cnt_q == div_c - UART_BAUD_W'(1)) begin
                  baud_cnt_d         = '0;
                  shift_d[bit_cnt_q] = rx_s_q;
                  bit_cnt_d          = bit_cnt_q + UART_BIT_CNT_W'(1);
                  if (bit_cnt_q == UART_BIT_CNT_W'(UART_FRAME_BITS - 1)) begin
                     state_d = STOP;
                  end
               end
            end
            STOP: begin
               if (baud_cnt_q == div_c - UART_BAUD_W'(1)) begin
                  baud_cnt_d = '0;
                  state_d    = IDLE;
                  if (!rx_s_q) begin
                     frame_err_d = 1'b1;
                  end else if (fifo_full) begin
                     // A pop on this same edge does not make room in time.
                     overrun_d = 1'b1;
                  end else begin
                     push_c = 1'b1;
                  end
               end
            end
            default: begin
               state_d    = IDLE;
               baud_cnt_d = '0;
            end
         endcase
      end
   end

   wbit_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .we_i    (push_c),
      .wdata_i (DATA_WIDTH'(shift_q)),
      .re_i    (rx_re_i),
      .rdata_o (dout_o),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign full_o      = fifo_full;
   assign empty_o     = fifo_empty;
   assign frame_err_o = frame_err_q;
   assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: vector table, directed corner cases, random frames vs. queue model.
module tb_uart_rx;
   import uart_rx_pkg::*;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [15:0] baud_div = 16'd16;
   logic        rx_en = 1'b1;
   logic        rx_bit = 1'b1;
   logic        rx_re = 1'b0;
   logic [7:0]  dout;
   logic        full, empty, frame_err, overrun;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc = 0;
   int start_cyc = 0;
   int fall_cyc = 0;
   int ferr_cnt = 0;
   int ovr_cnt = 0;
   int long_pulse = 0;
   logic prev_empty = 1'b1;
   logic prev_ferr = 1'b0;
   logic prev_ovr = 1'b0;
   logic [7:0] last_val = 8'h00;

   uart_rx #(.DATA_WIDTH(8), .FIFO_DEPTH(DEPTH)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .baud_div_i  (baud_div),
      .rx_en_i     (rx_en),
      .rx_bit_i    (rx_bit),
      .rx_re_i     (rx_re),
      .dout_o      (dout),
      .full_o      (full),
      .empty_o     (empty),
      .frame_err_o (frame_err),
      .overrun_o   (overrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Pulse counters, pulse-width watch and push-time capture, sampled mid-cycle.
   always @(negedge clk) begin
      if (frame_err === 1'b1) ferr_cnt++;
      if (overrun === 1'b1) ovr_cnt++;
      if ((frame_err === 1'b1 && prev_ferr) || (overrun === 1'b1 && prev_ovr)) long_pulse++;
      if (prev_empty && empty === 1'b0) fall_cyc = cyc;
      prev_ferr  = (frame_err === 1'b1);
      prev_ovr   = (overrun === 1'b1);
      prev_empty = (empty !== 1'b0);
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation time budget exceeded");
      $fatal(1);
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      rx_bit = 1'b1;
      repeat (n) step();
   endtask

   task automatic send_bit(input logic v, input int d);
      rx_bit = v;
      repeat (d) step();
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop, input int d);
      start_cyc = cyc;
      send_bit(1'b0, d);
      for (int i = 0; i < 8; i++) send_bit(b[i], d);
      send_bit(stop, d);
      rx_bit = 1'b1;
   endtask

   task automatic pop_expect(input string nm, input logic [7:0] exp);
      check(nm, 32'(dout), 32'(exp));
      last_val = exp;
      rx_re = 1'b1;
      step();
      rx_re = 1'b0;
   endtask

   typedef struct {
      logic [15:0] div_cfg;
      int          tx_div;
      logic [7:0]  data;
      logic        stop;
      logic        exp_empty;
      logic [7:0]  exp_dout;
      int          exp_ferr;
   } vec_t;

   vec_t vecs [7];
   logic [7:0] mq [$];

   initial begin
      int f0, o0, lat, d, nrd;
      logic [15:0] dc;
      logic [7:0]  b;
      logic        st;
      logic        exp_ovr;

      vecs[0] = '{16'd16, 16, 8'hA5, 1'b1, 1'b0, 8'hA5, 0};
      vecs[1] = '{16'd16, 16, 8'h3C, 1'b0, 1'b1, 8'hA5, 1};
      vecs[2] = '{16'd4,   4, 8'h00, 1'b1, 1'b0, 8'h00, 0};
      vecs[3] = '{16'd2,   4, 8'hFF, 1'b1, 1'b0, 8'hFF, 0};
      vecs[4] = '{16'd0,   4, 8'h81, 1'b1, 1'b0, 8'h81, 0};
      vecs[5] = '{16'd7,   7, 8'h5A, 1'b1, 1'b0, 8'h5A, 0};
      vecs[6] = '{16'd10, 10, 8'hC3, 1'b0, 1'b1, 8'h5A, 1};

      // Reset state
      #1 rst_n = 1'b0;
      #2;
      check("reset_empty", 32'(empty), 32'd1);
      check("reset_full", 32'(full), 32'd0);
      check("reset_ferr", 32'(frame_err), 32'd0);
      check("reset_ovr", 32'(overrun), 32'd0);
      repeat (3) step();
      rst_n = 1'b1;
      idle(4);

      // Vector table, FIFO empty before each frame
      foreach (vecs[k]) begin
         baud_div = vecs[k].div_cfg;
         idle(3);
         f0 = ferr_cnt; o0 = ovr_cnt;
         send_frame(vecs[k].data, vecs[k].stop, vecs[k].tx_div);
         idle(4);
         check($sformatf("vec%0d_empty", k), 32'(empty), 32'(vecs[k].exp_empty));
         check($sformatf("vec%0d_dout", k), 32'(dout), 32'(vecs[k].exp_dout));
         check($sformatf("vec%0d_ferr", k), 32'(ferr_cnt - f0), 32'(vecs[k].exp_ferr));
         check($sformatf("vec%0d_ovr", k), 32'(ovr_cnt - o0), 32'd0);
         if (!vecs[k].exp_empty) begin
            d = vecs[k].tx_div;
            lat = fall_cyc - start_cyc;
            check($sformatf("vec%0d_latency", k), 32'(lat), 32'(3 + d / 2 + 9 * d));
            pop_expect($sformatf("vec%0d_pop", k), vecs[k].exp_dout);
            check($sformatf("vec%0d_empty_after_pop", k), 32'(empty), 32'd1);
         end else begin
            last_val = vecs[k].exp_dout;
         end
      end

      // Read while empty is ignored
      rx_re = 1'b1; step(); rx_re = 1'b0;
      check("empty_read_dout", 32'(dout), 32'(last_val));
      check("empty_read_flag", 32'(empty), 32'd1);

      // 6-clock glitch at div=16 is rejected, then a normal frame still works
      baud_div = 16'd16;
      f0 = ferr_cnt; o0 = ovr_cnt;
      rx_bit = 1'b0;
      repeat (6) step();
      idle(40);
      check("glitch_empty", 32'(empty), 32'd1);
      check("glitch_ferr", 32'(ferr_cnt - f0), 32'd0);
      send_frame(8'h81, 1'b1, 16);
      idle(4);
      pop_expect("after_glitch_byte", 8'h81);

      // DEPTH+1 frames without reads
      baud_div = 16'd8;
      o0 = ovr_cnt;
      for (int i = 0; i <= DEPTH; i++) begin
         send_frame(8'(8'h10 + i), 1'b1, 8);
         idle(2);
      end
      check("fill_full", 32'(full), 32'd1);
      check("fill_ovr", 32'(ovr_cnt - o0), 32'd1);
      for (int i = 0; i < DEPTH; i++) pop_expect($sformatf("fill_pop%0d", i), 8'(8'h10 + i));
      check("fill_drained", 32'(empty), 32'd1);

      // Pop on the same edge as a push into a full FIFO
      for (int i = 0; i < DEPTH; i++) begin
         send_frame(8'(8'h20 + i), 1'b1, 8);
         idle(2);
      end
      o0 = ovr_cnt;
      fork
         send_frame(8'h99, 1'b1, 8);
         begin
            repeat (3 + 4 + 72 - 1) step();
            rx_re = 1'b1;
            step();
            rx_re = 1'b0;
         end
      join
      idle(4);
      check("pushpop_ovr", 32'(ovr_cnt - o0), 32'd1);
      check("pushpop_full", 32'(full), 32'd0);
      for (int i = 1; i < DEPTH; i++) pop_expect($sformatf("pushpop_pop%0d", i), 8'(8'h20 + i));
      check("pushpop_drained", 32'(empty), 32'd1);

      // Disable mid-data of 0xFF, then receive 0x12
      f0 = ferr_cnt; o0 = ovr_cnt;
      send_bit(1'b0, 8);
      for (int i = 0; i < 4; i++) send_bit(1'b1, 8);
      rx_en = 1'b0;
      for (int i = 0; i < 5; i++) send_bit(1'b1, 8);
      idle(5);
      rx_en = 1'b1;
      idle(5);
      check("disable_empty", 32'(empty), 32'd1);
      send_frame(8'h12, 1'b1, 8);
      idle(4);
      check("disable_ferr", 32'(ferr_cnt - f0), 32'd0);
      check("disable_ovr", 32'(ovr_cnt - o0), 32'd0);
      pop_expect("disable_byte", 8'h12);
      check("disable_drained", 32'(empty), 32'd1);

      // Reset mid-frame with two bytes queued
      send_frame(8'h11, 1'b1, 8); idle(2);
      send_frame(8'h22, 1'b1, 8); idle(2);
      check("prereset_empty", 32'(empty), 32'd0);
      send_bit(1'b0, 8);
      for (int i = 0; i < 3; i++) send_bit(1'b1, 8);
      rst_n = 1'b0;
      #1;
      check("midreset_empty", 32'(empty), 32'd1);
      check("midreset_full", 32'(full), 32'd0);
      check("midreset_ferr", 32'(frame_err), 32'd0);
      check("midreset_ovr", 32'(overrun), 32'd0);
      rx_bit = 1'b1;
      repeat (3) step();
      rst_n = 1'b1;
      idle(5);
      f0 = ferr_cnt;
      send_frame(8'h5A, 1'b1, 8);
      idle(4);
      check("postreset_ferr", 32'(ferr_cnt - f0), 32'd0);
      pop_expect("postreset_byte", 8'h5A);
      check("postreset_drained", 32'(empty), 32'd1);

      // Back-to-back frames at minimum divider
      baud_div = 16'd4;
      idle(3);
      f0 = ferr_cnt; o0 = ovr_cnt;
      send_frame(8'h00, 1'b1, 4);
      send_frame(8'hFF, 1'b1, 4);
      idle(4);
      check("b2b_ferr", 32'(ferr_cnt - f0), 32'd0);
      check("b2b_ovr", 32'(ovr_cnt - o0), 32'd0);
      pop_expect("b2b_first", 8'h00);
      pop_expect("b2b_second", 8'hFF);
      check("b2b_drained", 32'(empty), 32'd1);

      // Random frames against a queue model of the receive buffer
      for (int it = 0; it < 30; it++) begin
         dc = 16'($urandom_range(0, 12));
         d  = (dc < 16'd4) ? 4 : int'(dc);
         b  = 8'($urandom_range(0, 255));
         st = ($urandom_range(0, 4) != 0);
         baud_div = dc;
         idle(2);
         f0 = ferr_cnt; o0 = ovr_cnt;
         send_frame(b, st, d);
         idle(4);
         exp_ovr = 1'b0;
         if (st) begin
            if (mq.size() < DEPTH) mq.push_back(b);
            else exp_ovr = 1'b1;
         end
         check($sformatf("rnd%0d_ferr", it), 32'(ferr_cnt - f0), st ? 32'd0 : 32'd1);
         check($sformatf("rnd%0d_ovr", it), 32'(ovr_cnt - o0), 32'(exp_ovr));
         check($sformatf("rnd%0d_empty", it), 32'(empty), 32'(mq.size() == 0));
         check($sformatf("rnd%0d_full", it), 32'(full), 32'(mq.size() == DEPTH));
         nrd = $urandom_range(0, 2);
         for (int r = 0; r < nrd; r++) begin
            if (mq.size() > 0) begin
               pop_expect($sformatf("rnd%0d_pop", it), mq.pop_front());
            end else begin
               rx_re = 1'b1; step(); rx_re = 1'b0;
               check($sformatf("rnd%0d_emptyhold", it), 32'(dout), 32'(last_val));
            end
         end
      end
      while (mq.size() > 0) pop_expect("rnd_drain", mq.pop_front());
      check("rnd_drained", 32'(empty), 32'd1);

      check("pulse_width", 32'(long_pulse), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
